mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_div_step.sv | 27 ++
 rtl/mdu_iter.sv | 171 +++++++++++++++++
 tb/tb_mdu_iter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared decode constants and state type for the iterative multiply/divide unit.
// Holds the opcode/funct7 match values, the eight funct3 op codes and the FSM state enum.
// Also provides operand-signedness helpers used by the decode logic.
package mdu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // MUL only keeps the low half, which is the same for any signedness,
  // so it is treated as signed*signed to share the magnitude path.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring shift-subtract divide step on unsigned magnitudes.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: rem_in/next_bit form the shifted partial remainder, divisor is the
// magnitude being divided by; rem_out is the new partial remainder, q_bit the quotient bit.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            next_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted = {rem_in, next_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtract succeeds the true difference is below the divisor, so
  // the low XLEN bits of the wrapped subtraction are exact.
  assign diff    = shifted[XLEN-1:0] - divisor;
  assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit (one bit per cycle on magnitudes).
// Latency: XLEN+2 edges from accept for iterative ops, 1 edge for illegal/special ops.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush wins.
// Ports: clk/rst (async active-high); in_valid/in_ready with in_opcode, in_funct3,
// in_funct7, in_rs1, in_rs2; flush; out_valid/out_ready with out_result, out_err.
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier (MUL* finish 1 edge after accept).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic            live;        // low in reset so in_ready stays 0 until the first edge after it
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;         // product high half / partial remainder
  logic [XLEN-1:0] lo;          // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0] opb;         // multiplicand / divisor magnitude
  logic [2:0]      op;
  logic            neg_res;     // final result must be negated in FIX

  // Request decode
  logic            legal, a_neg, b_neg, div_zero, div_ovf, fast_hit, special, accept, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res, fix_res;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem;
  logic            div_q;

  function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] f3, input logic neg,
                                               input logic [2*XLEN-1:0] mag);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag : mag;
    return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  assign legal    = (in_opcode == OPC_OP) && (in_funct7 == F7_MULDIV);
  assign a_neg    = rs1_signed(in_funct3) && in_rs1[XLEN-1];
  assign b_neg    = rs2_signed(in_funct3) && in_rs2[XLEN-1];
  assign a_mag    = a_neg ? -in_rs1 : in_rs1;
  assign b_mag    = b_neg ? -in_rs2 : in_rs2;
  assign div_zero = in_funct3[2] && (in_rs2 == '0);
  assign div_ovf  = ((in_funct3 == F3_DIV) || (in_funct3 == F3_REM)) &&
                    (in_rs1 == MOST_NEG) && (&in_rs2);
  // Remainder takes the dividend's sign; product and quotient take the xor.
  assign neg_in   = (in_funct3[2] && in_funct3[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  assign fast_mag = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_hit = legal && !in_funct3[2];
  assign fast_res = mul_sel(in_funct3, neg_in, fast_mag);
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign special = !legal || div_zero || div_ovf || fast_hit;

  always_comb begin
    special_res = '0;
    if (!legal)        special_res = '0;
    else if (div_zero) special_res = in_funct3[1] ? in_rs1 : '1;
    else if (div_ovf)  special_res = in_funct3[1] ? '0 : in_rs1;
    else if (fast_hit) special_res = fast_res;
  end

  // Datapath step logic
  assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc),
    .next_bit(lo[XLEN-1]),
    .divisor (opb),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  always_comb begin
    fix_res = mul_sel(op, neg_res, {acc, lo});
    if (op[2]) begin
      if (op[1]) fix_res = neg_res ? -acc : acc;
      else       fix_res = neg_res ? -lo : lo;
    end
  end

  // FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      lo         <= '0;
      opb        <= '0;
      op         <= '0;
      neg_res    <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op      <= in_funct3;
          neg_res <= neg_in;
          cnt     <= '0;
          acc     <= '0;
          lo      <= a_mag;
          opb     <= b_mag;
          out_err <= !legal;
          if (special) out_result <= special_res;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            acc <= div_rem;
            lo  <= {lo[XLEN-2:0], div_q};
          end else begin
            // Shift {carry, acc, lo} right after the conditional add.
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        FIX:     out_result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): directed vectors, arithmetic model,
// per-cycle output compare against an expectation queue.
module tb_mdu_iter;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int LM = 1;
`else
  localparam int LM = XLEN + 2;
`endif
  localparam int LD = XLEN + 2;
  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7M = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      in_opcode = '0;
  logic [2:0]      in_funct3 = '0;
  logic [6:0]      in_funct7 = '0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;
  logic            out_err;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  exp_t q[$];
  vec_t vt[$];
  exp_t cur;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   active = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [6:0] opc, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, pu;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    if (opc != OPC || f7 != F7M) return {1'b1, 32'b0};
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ua); r = p[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
      3'd4: if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return {1'b0, r};
  endfunction

  function automatic vec_t mk(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                              input logic err, input int lat, input int hold);
    vec_t v;
    v.opc = opc; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.exp = e; v.err = err; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Compare process: every negedge while active.
  always @(negedge clk) begin
    if (active) begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (q.size() == 0)});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          cur = q[0];
          chk("out_result", {32'b0, out_result}, {32'b0, cur.res});
          chk("out_err", {63'b0, out_err}, {63'b0, cur.err});
          if (!seen) chk("latency", 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
          seen = 1'b1;
          if (out_ready && !flush) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (flush) begin
        q.delete();
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input vec_t v);
    int n;
    logic [32:0] m;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    m = model(v.opc, v.f7, v.f3, v.a, v.b);
    chk("model_pin", {31'b0, m}, {31'b0, v.err, v.exp});
    in_valid  = 1'b1;
    in_opcode = v.opc;
    in_funct7 = v.f7;
    in_funct3 = v.f3;
    in_rs1    = v.a;
    in_rs2    = v.b;
    out_ready = (v.hold == 0);
    @(posedge clk); #1;
    q.push_back('{res: m[31:0], err: m[32], lat: v.lat, acc_cyc: cyc});
    // Junk on the inputs after accept must not disturb the captured operands.
    in_valid  = 1'b0;
    in_opcode = 7'($urandom);
    in_funct7 = 7'($urandom);
    in_funct3 = 3'($urandom);
    in_rs1    = $urandom;
    in_rs2    = $urandom;
    if (v.hold > 0) begin
      n = 0;
      while (!out_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (v.hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  initial begin
    vt.push_back(mk(OPC, F7M, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, LM, 0));
    vt.push_back(mk(OPC, F7M, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, LD, 0));
    vt.push_back(mk(OPC, F7M, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0));
    vt.push_back(mk(OPC, F7M, 3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 1, 0));
    vt.push_back(mk(OPC, F7M, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0));
    vt.push_back(mk(OPC, F7M, 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 1, 0));
    vt.push_back(mk(OPC, F7M, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0));
    vt.push_back(mk(OPC, F7M, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0));
    vt.push_back(mk(OPC, 7'b0100000, 3'd0, 32'd3, 32'd4, 32'd0, 1'b1, 1, 5));
    vt.push_back(mk(7'b0110111, F7M, 3'd4, 32'd9, 32'd3, 32'd0, 1'b1, 1, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_result", {32'b0, out_result}, 64'd0);
    chk("rst_out_err", {63'b0, out_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {63'b0, in_ready}, 64'd1);
    active = 1'b1;

    foreach (vt[i]) issue(vt[i]);
    drain();

    // Flush in the middle of an iterative multiply
    issue(vt[0]);
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    issue(vt[10]);
    drain();

    // Reset in the middle of an iterative divide
    issue(vt[6]);
    repeat (5) begin
      @(posedge clk); #1;
    end
    active = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    seen = 1'b0;
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_out_result", {32'b0, out_result}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", {63'b0, in_ready}, 64'd1);
    active = 1'b1;
    issue(vt[0]);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
